fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants: state encoding, instruction width, reset PC.
// No logic, so no latency.
// No handshake of its own; it only carries the types used by the fetch handshakes.
package riscv_pkg;

    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    // Instruction fetches are word-granular, so the low two address bits are forced to zero.
    function automatic logic [ILEN-1:0] word_align(input logic [ILEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Groups the memory, redirect and decode signals of the fetch unit.
// No logic, so no latency.
// master = fetch unit side; slave = memory, branch unit and decode side.
interface fetch_unit_if;
    import riscv_pkg::*;

    logic            redirect;
    logic [ILEN-1:0] redirect_pc;
    logic            imem_req;
    logic [ILEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [ILEN-1:0] instr;
    logic [ILEN-1:0] instr_pc;
    logic            instr_ready;

    modport master (
        input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small register FIFO holding fetched {pc, instruction} pairs.
// Push is visible at the head the cycle after it is written; the head is read straight from registers.
// Push is refused when full unless a pop happens in the same cycle; flush overrides push and pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_dat_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_dat_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    // Pointer and occupancy update; depth is a power of two so pointers wrap naturally.
    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request at a time, responses buffered toward decode.
// rvalid in cycle N shows up as instr_valid in N+1; one instruction per two cycles at best.
// Stops requesting while the buffer is full; a redirect flushes the buffer and drops the in-flight reply.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam int CW  = $clog2(BUF_DEPTH + 1);
    localparam int CW1 = CW + 1;

    fetch_state_t     state_q, state_d;
    logic [ILEN-1:0]  pc_q, pc_d;
    logic             discard_q, discard_d;

    logic             buf_push, buf_pop, buf_full, buf_empty;
    logic [CW-1:0]    buf_count;
    logic [2*ILEN-1:0] buf_head;
    logic [CW1-1:0]   fill_after_push;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (2*ILEN)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (bus.redirect),
        .push_i     (buf_push),
        .push_dat_i ({pc_q, bus.imem_rdata}),
        .pop_i      (buf_pop),
        .head_dat_o (buf_head),
        .full_o     (buf_full),
        .empty_o    (buf_empty),
        .count_o    (buf_count)
    );

    assign bus.imem_req    = (state_q == REQ);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = ~buf_empty;
    assign bus.instr       = buf_head[ILEN-1:0];
    assign bus.instr_pc    = buf_head[2*ILEN-1:ILEN];

    // Next state: request sequencing, response capture, and redirect handling.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        discard_d       = discard_q;
        buf_push        = 1'b0;
        buf_pop         = ~buf_empty & bus.instr_ready;
        fill_after_push = {1'b0, buf_count} + CW1'(1) - CW1'(buf_pop);
        case (state_q)
            IDLE: begin
                // A redirect empties the buffer, so a slot is guaranteed next cycle.
                if (bus.redirect || !buf_full) state_d = REQ;
            end
            REQ: begin
                if (bus.imem_gnt) begin
                    state_d = WAIT;
                    // The granted address is the old path; its reply must be thrown away.
                    if (bus.redirect) discard_d = 1'b1;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    discard_d = 1'b0;
                    if (bus.redirect || discard_q) begin
                        state_d = REQ;
                    end else begin
                        buf_push = 1'b1;
                        pc_d     = pc_q + 32'd4;
                        state_d  = (fill_after_push < CW1'(BUF_DEPTH)) ? REQ : IDLE;
                    end
                end else if (bus.redirect) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = REQ;
        endcase
        if (bus.redirect) pc_d = word_align(bus.redirect_pc);
    end

    // State, PC and discard registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= REQ;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder, transaction-level buffer model, per-cycle compare.
// Directed scenarios pin the model with hand-computed literals.
// Decode readiness and grant availability are driven per scenario.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // stimulus knobs
    logic gnt_en   = 1'b0;
    int   rv_lat   = 1;
    logic force_rv = 1'b0;
    logic checking = 1'b0;

    // memory responder bookkeeping
    logic        pend_vld  = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_cnt  = 0;

    // model: what decode should see
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dat;
    } ent_t;
    ent_t        q[$];
    logic        out_vld  = 1'b0;
    logic        out_disc = 1'b0;
    logic [31:0] out_addr = '0;
    logic [31:0] exp_addr = RPC;
    int          cyc      = 0;
    logic [31:0] pop_pc[$];
    int          pop_cyc[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a + 32'h1300_0013;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic ncyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ncyc(2);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int lim);
        int k;
        k = 0;
        while (!bus.instr_valid && k < lim) begin
            ncyc(1);
            k++;
        end
        if (!bus.instr_valid) chk(nm, 64'd0, 64'd1);
    endtask

    task automatic wait_req(input string nm, input int lim);
        int k;
        k = 0;
        while (!bus.imem_req && k < lim) begin
            ncyc(1);
            k++;
        end
        if (!bus.imem_req) chk(nm, 64'd0, 64'd1);
    endtask

    // Model update on each edge from the values present before the edge.
    always @(posedge clk) begin
        ent_t e;
        cyc++;
        if (reset) begin
            q.delete();
            out_vld  = 1'b0;
            out_disc = 1'b0;
            exp_addr = RPC;
            pend_vld = 1'b0;
        end else begin
            if (bus.imem_rvalid) pend_vld = 1'b0;
            else if (pend_vld) pend_cnt--;
            if (bus.imem_req && bus.imem_gnt) begin
                pend_vld  = 1'b1;
                pend_addr = bus.imem_addr;
                pend_cnt  = rv_lat;
            end

            if (bus.redirect) begin
                q.delete();
                exp_addr = bus.redirect_pc & ~32'h3;
                out_disc = out_vld && !bus.imem_rvalid;
            end else begin
                if (q.size() > 0 && bus.instr_ready) begin
                    pop_pc.push_back(q[0].pc);
                    pop_cyc.push_back(cyc);
                    void'(q.pop_front());
                end
                if (bus.imem_rvalid && out_vld) begin
                    if (out_disc) begin
                        out_disc = 1'b0;
                    end else begin
                        e.pc  = out_addr;
                        e.dat = bus.imem_rdata;
                        q.push_back(e);
                        exp_addr = out_addr + 32'd4;
                    end
                end
            end
            if (bus.imem_rvalid) out_vld = 1'b0;
            if (bus.imem_req && bus.imem_gnt) begin
                out_vld  = 1'b1;
                out_addr = bus.imem_addr;
                out_disc = bus.redirect;
            end
        end
    end

    // Memory responder: grant on request, data rv_lat cycles after the grant.
    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.imem_gnt = gnt_en;
            if (force_rv || (pend_vld && pend_cnt == 1)) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = force_rv ? 32'hBAD0_BAD0 : memf(pend_addr);
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = '0;
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (checking) begin
                chk("instr_valid", bus.instr_valid, q.size() != 0);
                if (q.size() != 0) begin
                    chk("instr_pc", bus.instr_pc, q[0].pc);
                    chk("instr", bus.instr, q[0].dat);
                end
                if (bus.imem_req) chk("imem_addr", bus.imem_addr, exp_addr);
                if (out_vld || q.size() == DEPTH) chk("req_while_busy", bus.imem_req, 1'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cnt;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.instr_ready = 1'b0;
        @(negedge clk);
        // reset values
        chk("rst_valid", bus.instr_valid, 1'b0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        checking = 1'b1;

        // streaming: pcs 0,4,8 two cycles apart
        gnt_en = 1'b1; rv_lat = 1; bus.instr_ready = 1'b1;
        do_reset();
        chk("t1_req_after_reset", bus.imem_req, 1'b1);
        chk("t1_addr_after_reset", bus.imem_addr, RPC);
        base = pop_pc.size();
        ncyc(2);
        chk("t1_first_valid", bus.instr_valid, 1'b1);
        chk("t1_first_pc", bus.instr_pc, 32'h0);
        chk("t1_first_instr", bus.instr, 32'h1300_0013);
        ncyc(10);
        chk("t1_npops", pop_pc.size() >= base + 3, 1'b1);
        if (pop_pc.size() >= base + 3) begin
            chk("t1_pc0", pop_pc[base], 32'h0);
            chk("t1_pc1", pop_pc[base+1], 32'h4);
            chk("t1_pc2", pop_pc[base+2], 32'h8);
            chk("t1_gap01", pop_cyc[base+1] - pop_cyc[base], 2);
            chk("t1_gap12", pop_cyc[base+2] - pop_cyc[base+1], 2);
        end

        // decode stalled: buffer fills with two entries, requests stop
        bus.instr_ready = 1'b0;
        do_reset();
        ncyc(10);
        chk("t2_req_stopped", bus.imem_req, 1'b0);
        chk("t2_head_pc", bus.instr_pc, 32'h0);
        chk("t2_model_qsize", q.size(), 2);
        bus.instr_ready = 1'b1;
        ncyc(1);
        bus.instr_ready = 1'b0;
        chk("t2_head_after_pop", bus.instr_pc, 32'h4);
        chk("t2_req_still_off", bus.imem_req, 1'b0);
        ncyc(1);
        chk("t2_req_resumes", bus.imem_req, 1'b1);
        chk("t2_next_addr", bus.imem_addr, 32'h8);
        bus.instr_ready = 1'b1;
        ncyc(6);

        // redirect while waiting for 0x8
        rv_lat = 2;
        do_reset();
        cnt = 0;
        while (!(bus.imem_req && bus.imem_addr == 32'h8) && cnt < 40) begin
            ncyc(1);
            cnt++;
        end
        chk("t3_reach_addr8", bus.imem_addr, 32'h8);
        ncyc(1);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
        base = pop_pc.size();
        ncyc(1);
        bus.redirect = 1'b0;
        chk("t3_flushed", bus.instr_valid, 1'b0);
        wait_req("t3_req_timeout", 20);
        chk("t3_new_addr", bus.imem_addr, 32'h100);
        wait_valid("t3_valid_timeout", 20);
        chk("t3_new_pc", bus.instr_pc, 32'h100);
        ncyc(6);
        cnt = 0;
        for (int i = base; i < pop_pc.size(); i++) if (pop_pc[i] == 32'h8) cnt++;
        chk("t3_no_pc8", cnt, 0);

        // redirect to misaligned target with grant stalled
        gnt_en = 1'b0; rv_lat = 1;
        do_reset();
        bus.redirect = 1'b1; bus.redirect_pc = 32'h203;
        ncyc(1);
        bus.redirect = 1'b0;
        chk("t4_req", bus.imem_req, 1'b1);
        chk("t4_addr", bus.imem_addr, 32'h200);
        ncyc(3);
        chk("t4_addr_held", bus.imem_addr, 32'h200);
        gnt_en = 1'b1;
        wait_valid("t4_valid_timeout", 20);
        chk("t4_pc", bus.instr_pc, 32'h200);
        chk("t4_instr", bus.instr, 32'h1300_0213);

        // PC wraps past the top of the address space
        gnt_en = 1'b0;
        do_reset();
        bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        ncyc(1);
        bus.redirect = 1'b0; gnt_en = 1'b1;
        wait_valid("t5_valid_timeout", 20);
        chk("t5_pc_top", bus.instr_pc, 32'hFFFF_FFFC);
        chk("t5_req", bus.imem_req, 1'b1);
        chk("t5_wrap_addr", bus.imem_addr, 32'h0);

        // reset while waiting; stray rvalid after release is ignored
        gnt_en = 1'b1; rv_lat = 2;
        do_reset();
        wait_req("t6_req_timeout", 10);
        ncyc(1);
        chk("t6_in_wait", bus.imem_req, 1'b0);
        reset = 1'b1; gnt_en = 1'b0;
        ncyc(1);
        reset = 1'b0;
        chk("t6_req_after_rst", bus.imem_req, 1'b1);
        chk("t6_addr_after_rst", bus.imem_addr, RPC);
        force_rv = 1'b1;
        ncyc(2);
        force_rv = 1'b0;
        chk("t6_no_push", bus.instr_valid, 1'b0);
        chk("t6_addr_kept", bus.imem_addr, RPC);
        gnt_en = 1'b1;
        wait_valid("t6_valid_timeout", 20);
        chk("t6_pc", bus.instr_pc, RPC);
        chk("t6_instr", bus.instr, 32'h1300_0013);

        // redirects at varied offsets: coincident with rvalid, pops, full buffer
        for (int k = 0; k < 6; k++) begin
            gnt_en = 1'b1;
            rv_lat = 1 + (k % 2);
            bus.instr_ready = (k >= 3);
            do_reset();
            ncyc(k + 1);
            bus.redirect = 1'b1;
            bus.redirect_pc = 32'h1000 + k * 32'h44 + k;
            ncyc(1);
            bus.redirect = 1'b0;
            bus.instr_ready = 1'b1;
            ncyc(10);
        end

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
